uart_tx_ctrl: RTL
=================

// Module: uart_tx_ctrl
// PURPOSE
//   Frame controller for the UART transmitter, directly upstream of the registered 4:1 TX output mux.
//   Accepts one parallel byte, serializes it LSB first and computes the optional parity bit.
//   Drives the mux select so the line carries start, data, parity and stop bits, one bit per CLK cycle.
//   CLK is the bit-rate clock.
// PARAMETERS
//   DATA_WIDTH  8  width of P_DATA and number of data bits per frame
// PORTS
//   CLK         in   1           bit-rate clock; all state changes on rising edge
//   RST         in   1           synchronous, active-high reset
//   P_DATA      in   DATA_WIDTH  parallel byte to send
//   DATA_VALID  in   1           P_DATA valid; single-cycle qualifier
//   PAR_EN      in   1           1 = parity bit inserted after data
//   PAR_TYP     in   1           0 = even parity, 1 = odd parity
//   MUX_SEL     out  2           to mux SEL: 00 start(0), 01 stop/idle(1), 10 SER_DATA, 11 PAR_BIT
//   SER_DATA    out  1           current data bit (shift register LSB); feeds mux input 2
//   PAR_BIT     out  1           parity of the latched byte; feeds mux input 3
//   BUSY        out  1           frame in progress; high from START through STOP
// BEHAVIOUR
//   Reset: on any rising CLK with RST=1 -> state IDLE, MUX_SEL=01, BUSY=0, SER_DATA=0, PAR_BIT=0, bit count 0.
//   RST is sampled only on CLK. It overrides all other inputs, including mid-frame; a partial frame is discarded.
//   FSM states: IDLE, START, DATA, PARITY, STOP. The state register is the only timing source.
//   Outputs are Moore-decoded from state: IDLE/STOP->01, START->00, DATA->10, PARITY->11.
//   BUSY=1 in START, DATA, PARITY and STOP; BUSY=0 only in IDLE.
//   Accept: DATA_VALID=1 sampled in IDLE or STOP -> next cycle START. On that edge latch P_DATA, PAR_EN and PAR_TYP.
//   DATA_VALID in START, DATA or PARITY is ignored. No buffering; the upstream side must watch BUSY.
//   START -> DATA after exactly 1 cycle.
//   DATA lasts DATA_WIDTH cycles. SER_DATA = bit0 in the first DATA cycle; shift right each DATA cycle.
//   Bit counter counts 0..DATA_WIDTH-1. On the last count go to PARITY if latched PAR_EN=1, else to STOP. Counter clears on exit.
//   PARITY lasts 1 cycle -> STOP.
//   PAR_BIT = ^data XOR PAR_TYP. It is computed at latch time and held stable until the next accept.
//   STOP lasts 1 cycle. If DATA_VALID=1 in STOP -> START (back-to-back, no idle gap); else -> IDLE.
//   Frame length in CLK cycles: 1+DATA_WIDTH+PAR_EN+1 (10 or 11 for the default).
//   Latency: accept edge k -> MUX_SEL=00 during cycle k+1. The mux registers its output, so the line shows the start bit from cycle k+2.
//   Changes on P_DATA, PAR_EN or PAR_TYP after accept have no effect on the frame in flight.
//   SER_DATA in non-DATA states: holds the current shift register LSB; don't-care because the mux does not select it.
//   Default case of the FSM returns to IDLE. No latches and no unreachable-state lockup.
// TESTING
//   1. RST=1 for 2 cycles -> MUX_SEL=01, BUSY=0, PAR_BIT=0; line idles high through the mux.
//   2. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, pulse DATA_VALID -> MUX_SEL 00, 10x8, 11, 01; SER_DATA 1,0,1,0,0,1,0,1; PAR_BIT=0; BUSY high 11 cycles.
//   3. P_DATA=0x00, PAR_EN=1, PAR_TYP=1 -> PAR_BIT=1; P_DATA=0x01, PAR_TYP=1 -> PAR_BIT=0.
//   4. P_DATA=0xFF, PAR_EN=0 -> no 11 select; frame is 10 cycles; STOP follows the 8th data bit.
//   5. Back-to-back: 0x3C, then DATA_VALID=1 with 0xC3 in the STOP cycle -> next cycle START with no IDLE.
//   5. (cont.) A DATA_VALID pulse with 0x55 during DATA is ignored; the frame stays 0x3C.
//   6. RST=1 during the 4th DATA cycle of 0x5A -> next cycle IDLE, MUX_SEL=01, BUSY=0.
//   6. (cont.) A new accept of 0x81 then produces a clean full frame.
//   Bench: reference model of the 10/11-bit frame on the mux output, compared bit-for-bit with 1-cycle mux lag.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: serializes one latched byte LSB first and
// steers the downstream registered 4:1 TX mux through start, data, parity and stop.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            MUX_SEL,
    output logic                  SER_DATA,
    output logic                  PAR_BIT,
    output logic                  BUSY
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_STOP  = 2'b01;
    localparam logic [1:0] SEL_DATA  = 2'b10;
    localparam logic [1:0] SEL_PAR   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic                    par_en_r;
    logic                    par_bit_r;
    logic [1:0]              mux_sel_r;
    logic                    busy_r;
    logic                    accept_s;
    logic [1:0]              mux_sel_next_s;
    logic                    busy_next_s;

    // Parity of the data word, inverted for odd parity.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                         input logic odd);
        return (^data) ^ odd;
    endfunction

    // Next-state selection and look-ahead decode of the Moore outputs.
    always_comb begin
        next_state_s   = state_r;
        accept_s       = 1'b0;
        mux_sel_next_s = SEL_STOP;
        busy_next_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (DATA_VALID) begin
                    accept_s     = 1'b1;
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                next_state_s = ST_DATA;
            end
            ST_DATA: begin
                if (cnt_r == LAST_CNT) begin
                    next_state_s = par_en_r ? ST_PARITY : ST_STOP;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                next_state_s = ST_STOP;
            end
            ST_STOP: begin
                // A new byte in the stop cycle chains directly into the next frame.
                if (DATA_VALID) begin
                    accept_s     = 1'b1;
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase

        case (next_state_s)
            ST_START:  mux_sel_next_s = SEL_START;
            ST_DATA:   mux_sel_next_s = SEL_DATA;
            ST_PARITY: mux_sel_next_s = SEL_PAR;
            ST_STOP:   mux_sel_next_s = SEL_STOP;
            default:   mux_sel_next_s = SEL_STOP;
        endcase

        if (next_state_s != ST_IDLE) begin
            busy_next_s = 1'b1;
        end else begin
            busy_next_s = 1'b0;
        end
    end

    // State, datapath and registered output update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            shift_r   <= '0;
            par_en_r  <= 1'b0;
            par_bit_r <= 1'b0;
            mux_sel_r <= SEL_STOP;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            mux_sel_r <= mux_sel_next_s;
            busy_r    <= busy_next_s;

            if (accept_s) begin
                shift_r   <= P_DATA;
                par_en_r  <= PAR_EN;
                par_bit_r <= calc_parity(P_DATA, PAR_TYP);
            end else if (state_r == ST_DATA) begin
                shift_r   <= shift_r >> 1'b1;
            end else begin
                shift_r   <= shift_r;
            end

            if ((state_r == ST_DATA) && (cnt_r != LAST_CNT)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign MUX_SEL  = mux_sel_r;
    assign SER_DATA = shift_r[0];
    assign PAR_BIT  = par_bit_r;
    assign BUSY     = busy_r;

endmodule
